stopwatch_ctrl: RTL and testbench

Control and timing sequencer for the stopwatch counter datapath. Conditions the pause and reset pushbuttons and runs the IDLE/RUNNING/PAUSED state machine. Generates the 1 Hz count enable, the 2 Hz adjust enable, the clear pulse and the display blink that drive the minutes/seconds counter. Sits between board I/O and the counter; the counter only advances on this block's enables.

---
 rtl/stopwatch_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 47 ++++
 rtl/stopwatch_ctrl.sv | 155 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control block and its bench.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } sw_state_t;

    localparam int DEFAULT_TICK_DIV        = 100_000_000;
    localparam int DEFAULT_ADJ_DIV         = 50_000_000;
    localparam int DEFAULT_BLINK_DIV       = 25_000_000;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

    localparam int SIM_TICK_DIV        = 10;
    localparam int SIM_ADJ_DIV         = 5;
    localparam int SIM_BLINK_DIV       = 4;
    localparam int SIM_DEBOUNCE_CYCLES = 3;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int div_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: two-flop synchronizer, stability counter and a
// single-cycle pulse when the accepted level rises.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CW = div_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] stable_cnt;

    // The counter measures how long the synced level has disagreed with the
    // accepted one; any return to agreement restarts the measurement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            level      <= 1'b0;
            stable_cnt <= '0;
            press      <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                level      <= sync2;
                stable_cnt <= '0;
                press      <= sync2;
            end else begin
                stable_cnt <= stable_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button conditioning, IDLE/RUNNING/PAUSED control and
// the count, adjust and blink timebases feeding the minutes/seconds counter.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV        = DEFAULT_TICK_DIV,
    parameter int ADJ_DIV         = DEFAULT_ADJ_DIV,
    parameter int BLINK_DIV       = DEFAULT_BLINK_DIV,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_pause,
    input  logic btn_reset,
    input  logic sw_adj,
    input  logic sw_sel,
    output logic count_tick,
    output logic adj_tick,
    output logic adj_active,
    output logic adj_sel,
    output logic clear,
    output logic running,
    output logic blink
);

    localparam int TW = div_width(TICK_DIV);
    localparam int AW = div_width(ADJ_DIV);
    localparam int BW = div_width(BLINK_DIV);

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ADJ_LAST   = AW'(ADJ_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    sw_state_t     state;
    sw_state_t     state_next;
    logic          running_next;
    logic          clear_next;
    logic          pause_press;
    logic          reset_press;
    logic          adj_sync1;
    logic          sel_sync1;
    logic [TW-1:0] tick_cnt;
    logic [AW-1:0] adj_cnt;
    logic [BW-1:0] blink_cnt;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_db (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_pause),
        .press (pause_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reset_db (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_reset),
        .press (reset_press)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adj_sync1  <= 1'b0;
            adj_active <= 1'b0;
            sel_sync1  <= 1'b0;
            adj_sel    <= 1'b0;
        end else begin
            adj_sync1  <= sw_adj;
            adj_active <= adj_sync1;
            sel_sync1  <= sw_sel;
            adj_sel    <= sel_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            running <= 1'b0;
            clear   <= 1'b0;
        end else begin
            state   <= state_next;
            running <= running_next;
            clear   <= clear_next;
        end
    end

    // A reset press overrides a simultaneous pause press.
    always_comb begin
        state_next = state;
        if (reset_press) begin
            state_next = IDLE;
        end else if (pause_press) begin
            case (state)
                IDLE:    state_next = RUNNING;
                RUNNING: state_next = PAUSED;
                PAUSED:  state_next = RUNNING;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        running_next = (state_next == RUNNING);
        clear_next   = reset_press;
    end

    // Holding rather than clearing outside RUNNING keeps the fractional second.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt   <= '0;
            count_tick <= 1'b0;
        end else begin
            count_tick <= 1'b0;
            if (reset_press) begin
                tick_cnt <= '0;
            end else if (state == RUNNING && !adj_active) begin
                if (tick_cnt == TICK_LAST) begin
                    tick_cnt   <= '0;
                    count_tick <= 1'b1;
                end else begin
                    tick_cnt <= tick_cnt + TW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adj_cnt  <= '0;
            adj_tick <= 1'b0;
        end else begin
            adj_tick <= 1'b0;
            if (!adj_active) begin
                adj_cnt <= '0;
            end else if (adj_cnt == ADJ_LAST) begin
                adj_cnt  <= '0;
                adj_tick <= 1'b1;
            end else begin
                adj_cnt <= adj_cnt + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink     <= ~blink;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: a cycle-level behavioural model is
// compared on every cycle, plus hand-computed latency and count checks.
`timescale 1ns/1ps
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam int TD = SIM_TICK_DIV;
    localparam int AD = SIM_ADJ_DIV;
    localparam int BD = SIM_BLINK_DIV;
    localparam int DB = SIM_DEBOUNCE_CYCLES;

    localparam int SIG_RUNNING = 0;
    localparam int SIG_TICK    = 1;
    localparam int SIG_BLINK   = 2;
    localparam int SIG_CLEAR   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_pause = 1'b0;
    logic btn_reset = 1'b0;
    logic sw_adj = 1'b0;
    logic sw_sel = 1'b0;
    logic count_tick, adj_tick, adj_active, adj_sel, clear, running, blink;

    int errors = 0;
    int checks = 0;

    stopwatch_ctrl #(
        .TICK_DIV        (TD),
        .ADJ_DIV         (AD),
        .BLINK_DIV       (BD),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_pause  (btn_pause),
        .btn_reset  (btn_reset),
        .sw_adj     (sw_adj),
        .sw_sel     (sw_sel),
        .count_tick (count_tick),
        .adj_tick   (adj_tick),
        .adj_active (adj_active),
        .adj_sel    (adj_sel),
        .clear      (clear),
        .running    (running),
        .blink      (blink)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 running, 2 paused. Ticks come from
    // cumulative counted cycles, blink from elapsed cycles since reset.
    int          mode = 0;
    int          run_cycles = 0;
    int          adj_cycles = 0;
    int          elapsed = 0;
    bit [1:0]    pipe_p = '0, pipe_r = '0, pipe_a = '0, pipe_s = '0;
    logic [DB-1:0] hist_p = '0, hist_r = '0;
    bit          acc_p = 0, acc_r = 0, pr_p = 0, pr_r = 0;
    bit          exp_tick = 0, exp_adj_tick = 0, exp_clear = 0;
    bit          exp_running = 0, exp_blink = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mode = 0; run_cycles = 0; adj_cycles = 0; elapsed = 0;
            pipe_p = '0; pipe_r = '0; pipe_a = '0; pipe_s = '0;
            hist_p = '0; hist_r = '0;
            acc_p = 0; acc_r = 0; pr_p = 0; pr_r = 0;
            exp_tick = 0; exp_adj_tick = 0; exp_clear = 0;
            exp_running = 0; exp_blink = 0;
        end else begin
            exp_tick  = 0;
            exp_clear = 0;
            if (pr_r) begin
                mode = 0;
                run_cycles = 0;
                exp_clear = 1;
            end else begin
                if (mode == 1 && !pipe_a[1]) begin
                    run_cycles++;
                    exp_tick = (run_cycles % TD) == 0;
                end
                if (pr_p) mode = (mode == 1) ? 2 : 1;
            end
            exp_running = (mode == 1);
            if (pipe_a[1]) begin
                adj_cycles++;
                exp_adj_tick = (adj_cycles % AD) == 0;
            end else begin
                adj_cycles = 0;
                exp_adj_tick = 0;
            end
            elapsed++;
            exp_blink = ((elapsed / BD) % 2) == 1;
            // A button level is accepted once the last DB synced samples all disagree with it.
            hist_p = (hist_p << 1) | DB'(pipe_p[1]);
            hist_r = (hist_r << 1) | DB'(pipe_r[1]);
            pr_p = 0;
            pr_r = 0;
            if (acc_p ? (hist_p == '0) : (hist_p == '1)) begin
                acc_p = ~acc_p;
                pr_p  = acc_p;
            end
            if (acc_r ? (hist_r == '0) : (hist_r == '1)) begin
                acc_r = ~acc_r;
                pr_r  = acc_r;
            end
            pipe_p = {pipe_p[0], btn_pause};
            pipe_r = {pipe_r[0], btn_reset};
            pipe_a = {pipe_a[0], sw_adj};
            pipe_s = {pipe_s[0], sw_sel};
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic pause, input logic reset, input logic adj, input logic sel);
        btn_pause = pause;
        btn_reset = reset;
        sw_adj    = adj;
        sw_sel    = sel;
    endtask

    function automatic logic sigOf(input int which);
        case (which)
            SIG_RUNNING: return running;
            SIG_TICK:    return count_tick;
            SIG_BLINK:   return blink;
            SIG_CLEAR:   return clear;
            default:     return adj_tick;
        endcase
    endfunction

    // Returns the number of falling edges until the signal shows the level, or -1 on timeout.
    task automatic waitLevel(input int which, input logic level, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (sigOf(which) == level) begin
                n = i;
                break;
            end
        end
    endtask

    always @(negedge clk) begin
        checkOutput("count_tick", count_tick, exp_tick);
        checkOutput("adj_tick", adj_tick, exp_adj_tick);
        checkOutput("adj_active", adj_active, pipe_a[1]);
        checkOutput("adj_sel", adj_sel, pipe_s[1]);
        checkOutput("clear", clear, exp_clear);
        checkOutput("running", running, exp_running);
        checkOutput("blink", blink, exp_blink);
    end

    initial begin
        int n;
        int rise_at;
        int first_tick;
        int clear_cnt;
        int first_clear;
        int adj_rise;
        int sel_rise;
        int adj_cnt;
        int first_adj;
        int tick_cnt;

        $display("[TB] reset and blink");
        applyStimulus(0, 0, 0, 0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_running", running, 0);
        checkOutput("reset_clear", clear, 0);
        waitLevel(SIG_BLINK, 1'b1, 20, n);
        checkOutput("blink_first_toggle", n, 4);
        waitLevel(SIG_BLINK, 1'b0, 20, n);
        checkOutput("blink_second_toggle", n, 4);

        $display("[TB] held pause button");
        rise_at = -1;
        first_tick = -1;
        applyStimulus(1, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (running && rise_at < 0) rise_at = i;
            if (count_tick && first_tick < 0) first_tick = i;
        end
        applyStimulus(0, 0, 0, 0);
        checkOutput("pause_to_running", rise_at, 6);
        checkOutput("running_to_first_tick", first_tick - rise_at, 10);
        waitLevel(SIG_TICK, 1'b1, 20, n);
        checkOutput("second_tick_after_release", n, 6);

        $display("[TB] pause preserves fraction");
        repeat (8) @(negedge clk);
        applyStimulus(1, 0, 0, 0);
        repeat (8) @(negedge clk);
        applyStimulus(0, 0, 0, 0);
        checkOutput("paused_running_low", running, 0);
        tick_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (count_tick) tick_cnt++;
        end
        checkOutput("ticks_while_paused", tick_cnt, 0);
        applyStimulus(1, 0, 0, 0);
        waitLevel(SIG_RUNNING, 1'b1, 20, n);
        checkOutput("resume_latency", n, 6);
        waitLevel(SIG_TICK, 1'b1, 20, n);
        checkOutput("resume_to_tick", n, 6);
        applyStimulus(0, 0, 0, 0);

        $display("[TB] glitch and simultaneous presses");
        repeat (10) @(negedge clk);
        applyStimulus(1, 0, 0, 0);
        repeat (2) @(negedge clk);
        applyStimulus(0, 0, 0, 0);
        repeat (15) @(negedge clk);
        checkOutput("glitch_keeps_running", running, 1);
        clear_cnt = 0;
        first_clear = -1;
        applyStimulus(1, 1, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (clear) begin
                clear_cnt++;
                if (first_clear < 0) first_clear = i;
            end
        end
        applyStimulus(0, 0, 0, 0);
        checkOutput("both_clear_latency", first_clear, 6);
        checkOutput("both_clear_pulses", clear_cnt, 1);
        checkOutput("both_running_low", running, 0);
        repeat (10) @(negedge clk);

        $display("[TB] adjust mode");
        applyStimulus(1, 0, 0, 0);
        waitLevel(SIG_RUNNING, 1'b1, 20, n);
        checkOutput("idle_to_running", n, 6);
        applyStimulus(0, 0, 0, 0);
        repeat (13) @(negedge clk);
        adj_rise = -1; sel_rise = -1; adj_cnt = 0; first_adj = -1; tick_cnt = 0;
        applyStimulus(0, 0, 1, 1);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (adj_active && adj_rise < 0) adj_rise = i;
            if (adj_sel && sel_rise < 0) sel_rise = i;
            if (adj_tick) begin
                adj_cnt++;
                if (first_adj < 0) first_adj = i;
            end
            if (count_tick && i >= 3 && i <= 32) tick_cnt++;
            if (i == 30) applyStimulus(0, 0, 0, 0);
        end
        checkOutput("adj_active_latency", adj_rise, 2);
        checkOutput("adj_sel_latency", sel_rise, 2);
        checkOutput("adj_first_tick", first_adj - adj_rise, 5);
        checkOutput("adj_tick_count", adj_cnt, 6);
        checkOutput("count_ticks_in_adjust", tick_cnt, 0);

        $display("[TB] asynchronous reset mid-count");
        waitLevel(SIG_TICK, 1'b1, 20, n);
        checkOutput("tick_before_rst_found", (n > 0) ? 1 : 0, 1);
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_running", running, 0);
        checkOutput("rst_count_tick", count_tick, 0);
        checkOutput("rst_clear", clear, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (clear) clear_cnt++;
        end
        checkOutput("no_clear_after_rst", clear_cnt, 0);
        applyStimulus(1, 0, 0, 0);
        waitLevel(SIG_RUNNING, 1'b1, 20, n);
        checkOutput("post_rst_running", n, 6);
        waitLevel(SIG_TICK, 1'b1, 20, n);
        checkOutput("post_rst_first_tick", n, 10);
        applyStimulus(0, 0, 0, 0);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
